// File: rtl/afifo_wr_front.sv
// Async FIFO write-side front end: 2-entry skid buffer feeding winc/wdata, plus registered fill level.
// Accepted words reach wdata one edge later; s_ready drops when both entries are held and wfull stalls the write.
module afifo_wr_front #(
  parameter int DWIDTH   = 8,
  parameter int PWIDTH   = 4,
  parameter int AFULL_TH = 6
) (
  input  logic              wclk,
  input  logic              wrst_n,
  input  logic              s_valid,
  input  logic [DWIDTH-1:0] s_data,
  output logic              s_ready,
  input  logic              wfull,
  input  logic [PWIDTH-1:0] wptr,
  input  logic [PWIDTH-1:0] wq2_rptr,
  output logic              winc,
  output logic [DWIDTH-1:0] wdata,
  output logic [PWIDTH-1:0] wlevel,
  output logic              walmost_full,
  output logic              busy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [PWIDTH-1:0] AFULL_LV = PWIDTH'(AFULL_TH);

  state_t            state, state_nxt;
  logic [DWIDTH-1:0] main_dat, main_nxt;
  logic [DWIDTH-1:0] skid_dat, skid_nxt;
  logic              main_valid;
  logic              accept;
  logic              drain;
  logic [PWIDTH-1:0] wbin, rbin, level;

  function automatic logic [PWIDTH-1:0] gray2bin(input logic [PWIDTH-1:0] g);
    logic [PWIDTH-1:0] b;
    for (int i = 0; i < PWIDTH; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  assign main_valid = (state != EMPTY);
  assign winc       = main_valid & ~wfull;
  assign drain      = winc;
  assign accept     = s_valid & s_ready;
  assign wdata      = main_dat;
  assign busy       = main_valid;

  always_comb begin
    state_nxt = state;
    main_nxt  = main_dat;
    skid_nxt  = skid_dat;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt = ONE;
          main_nxt  = s_data;
        end
      end
      ONE: begin
        if (accept && drain) begin
          main_nxt = s_data;
        end else if (accept) begin
          state_nxt = TWO;
          skid_nxt  = s_data;
        end else if (drain) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        // s_ready is low here, so only a drain can move the state
        if (drain) begin
          state_nxt = ONE;
          main_nxt  = skid_dat;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state    <= EMPTY;
      main_dat <= '0;
      skid_dat <= '0;
      s_ready  <= 1'b0;
    end else begin
      state    <= state_nxt;
      main_dat <= main_nxt;
      skid_dat <= skid_nxt;
      s_ready  <= (state_nxt != TWO);
    end
  end

  // Modular subtraction absorbs pointer wrap; sync lag on rptr makes this pessimistic
  assign wbin  = gray2bin(wptr);
  assign rbin  = gray2bin(wq2_rptr);
  assign level = wbin - rbin;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wlevel       <= '0;
      walmost_full <= 1'b0;
    end else begin
      wlevel       <= level;
      walmost_full <= (level >= AFULL_LV);
    end
  end

endmodule

// File: tb/tb_afifo_wr_front.sv
// Randomized bench for afifo_wr_front against a queue-based reference model.
module tb_afifo_wr_front;

  logic       wclk = 1'b0;
  logic       wrst_n;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       wfull;
  logic [3:0] wptr;
  logic [3:0] wq2_rptr;
  logic       winc;
  logic [7:0] wdata;
  logic [3:0] wlevel;
  logic       walmost_full;
  logic       busy;

  int err_cnt = 0;
  int chk_cnt = 0;

  logic [7:0] q[$];
  logic       exp_rdy;
  int         exp_lvl;
  logic       exp_af;
  logic       acc;
  int         wr_cnt;

  always #5 wclk = ~wclk;

  afifo_wr_front #(.DWIDTH(8), .PWIDTH(4), .AFULL_TH(6)) dut (
    .wclk        (wclk),
    .wrst_n      (wrst_n),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .wfull       (wfull),
    .wptr        (wptr),
    .wq2_rptr    (wq2_rptr),
    .winc        (winc),
    .wdata       (wdata),
    .wlevel      (wlevel),
    .walmost_full(walmost_full),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Binary index whose Gray code matches g, found by search
  function automatic int g2b(input logic [3:0] g);
    for (int k = 0; k < 16; k++) begin
      if (4'(k ^ (k >> 1)) == g) return k;
    end
    return 0;
  endfunction

  // Called at the falling edge: compare outputs, then advance the model across the next rising edge
  task automatic check_and_update();
    logic exp_winc;
    chk("s_ready", 32'(s_ready), 32'(exp_rdy));
    chk("busy", 32'(busy), 32'(q.size() != 0));
    exp_winc = (q.size() != 0) && !wfull;
    chk("winc", 32'(winc), 32'(exp_winc));
    chk("winc_while_wfull", 32'(winc & wfull), 32'(0));
    if (exp_winc) begin
      chk("wdata", 32'(wdata), 32'(q[0]));
      void'(q.pop_front());
      wr_cnt++;
    end
    chk("wlevel", 32'(wlevel), 32'(exp_lvl));
    chk("walmost_full", 32'(walmost_full), 32'(exp_af));
    exp_lvl = (g2b(wptr) - g2b(wq2_rptr) + 16) % 16;
    exp_af  = (exp_lvl >= 6);
    acc = s_valid && exp_rdy;
    if (acc) q.push_back(s_data);
    exp_rdy = (q.size() < 2);
  endtask

  task automatic step();
    @(negedge wclk);
    check_and_update();
    @(posedge wclk);
    #1;
  endtask

  task automatic do_reset();
    wrst_n  = 1'b0;
    q.delete();
    exp_rdy = 1'b0;
    exp_lvl = 0;
    exp_af  = 1'b0;
    repeat (3) @(posedge wclk);
    @(negedge wclk);
    chk("rst_s_ready", 32'(s_ready), 32'(0));
    chk("rst_winc", 32'(winc), 32'(0));
    chk("rst_wlevel", 32'(wlevel), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    wrst_n = 1'b1;
    check_and_update();
    @(posedge wclk);
    #1;
  endtask

  // Offer words on the valid/ready stream, holding each until accepted
  task automatic push_words(input logic [7:0] words[$], input int max_cycles);
    int idx = 0;
    int cyc = 0;
    while (idx < words.size() && cyc < max_cycles) begin
      s_valid = 1'b1;
      s_data  = words[idx];
      step();
      if (acc) idx++;
      cyc++;
    end
    if (idx < words.size()) chk("push_timeout", 32'(idx), 32'(words.size()));
    s_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] w[$];
    int         wr_base;
    logic [3:0] b;

    wrst_n = 1'b0; s_valid = 1'b1; s_data = 8'h55; wfull = 1'b0;
    wptr = 4'b0000; wq2_rptr = 4'b0000; wr_cnt = 0;

    // Reset with upstream valid held high
    do_reset();
    s_valid = 1'b0;
    step();
    chk("no_write_after_reset", 32'(wr_cnt), 32'(0));

    // Full-throughput stream
    w = {8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    wr_base = wr_cnt;
    push_words(w, 20);
    repeat (3) step();
    chk("stream_writes", 32'(wr_cnt - wr_base), 32'(8));

    // Backpressure from wfull: two words buffered, third held upstream
    wfull = 1'b1;
    w = {8'hA1, 8'hA2};
    push_words(w, 10);
    s_valid = 1'b1; s_data = 8'hA3;
    step();
    chk("a3_held", 32'(acc), 32'(0));
    wfull = 1'b0;
    wr_base = wr_cnt;
    w = {8'hA3};
    push_words(w, 10);
    repeat (3) step();
    chk("bp_writes", 32'(wr_cnt - wr_base), 32'(3));

    // Level and almost-full, including wrap
    wptr = 4'b0101; wq2_rptr = 4'b0001; step(); step();
    chk("lvl5", 32'(wlevel), 32'(5));
    wptr = 4'b0100; step(); step();
    chk("lvl6_af", 32'(walmost_full), 32'(1));
    wptr = 4'b0001; wq2_rptr = 4'b1011; step(); step();
    chk("lvl_wrap", 32'(wlevel), 32'(4));

    // Reset asserted while both entries are held
    wfull = 1'b1;
    w = {8'hC1, 8'hC2};
    push_words(w, 10);
    step();
    chk("in_two", 32'(s_ready), 32'(0));
    #2;
    wrst_n = 1'b0;
    #1;
    chk("mid_rst_winc", 32'(winc), 32'(0));
    chk("mid_rst_s_ready", 32'(s_ready), 32'(0));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    wfull = 1'b0;
    do_reset();
    wr_base = wr_cnt;
    repeat (4) step();
    chk("no_stale_write", 32'(wr_cnt - wr_base), 32'(0));
    w = {8'hD5};
    push_words(w, 5);
    repeat (2) step();
    chk("post_rst_write", 32'(wr_cnt - wr_base), 32'(1));

    // Random valid/wfull/pointer traffic
    s_valid = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (!s_valid || acc) begin
        s_valid = ($urandom_range(0, 99) < 70);
        s_data  = 8'($urandom);
      end
      wfull = ($urandom_range(0, 99) < 30);
      b = 4'($urandom); wptr = b ^ (b >> 1);
      b = 4'($urandom); wq2_rptr = b ^ (b >> 1);
      step();
    end
    s_valid = 1'b0; wfull = 1'b0;
    repeat (4) step();
    chk("drained", 32'(q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
